ps2_key_sequencer: RTL and testbench

//  Converts PS/2 scan codes to terminal byte streams: plain ASCII, or ANSI/VT52 escape sequences.

---
 rtl/ps2_key_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_sequencer.sv
// PS/2 key-code to terminal byte-stream sequencer (ASCII, ANSI/VT100, VT52) with an output FIFO.
// Optional xterm modifier parameters are enabled by defining PS2_KEY_SEQUENCER_MODIFIERS_EN.
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_low,
  output logic                             scan_code_ready,
  input  logic                             scan_code_valid,
  input  logic [7:0]                       scan_code_byte,
  input  logic                             scan_code_extended,
  input  logic                             scan_code_special,
  input  logic                             num_lock,
  input  logic                             control,
  input  logic                             caps_lock,
  input  logic                             shift,
  input  logic                             alt,
  input  logic                             vt52_mode,
  input  logic                             cursor_app_mode,
  output logic                             lookup_ce,
  output logic                             lookup_extended,
  output logic [7:0]                       lookup_scan_code,
  output logic                             lookup_num_lock,
  output logic                             lookup_control,
  output logic                             lookup_caps_lock,
  output logic                             lookup_shift,
  input  logic [7:0]                       key_code_q,
  input  logic                             character_ready,
  output logic                             character_valid,
  output logic [7:0]                       character_byte,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_ESC, S_INTRO, S_TENS, S_ONES, S_SEMI, S_MOD, S_FINAL
  } state_t;

  state_t          state, state_next;
  logic [6:0]      key_q;
  logic            vt52_q, app_q;
  logic [3:0]      mod_q, mod_now;
  logic [LW-1:0]   level;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            push, pop, room;
  logic [7:0]      push_byte;

`ifdef PS2_KEY_SEQUENCER_MODIFIERS_EN
  assign mod_now = 4'd1 + {3'b000, shift} + {2'b00, alt, 1'b0} + {1'b0, control, 2'b00};
`else
  logic unused_alt;
  assign unused_alt = alt;
  assign mod_now    = 4'd1;
`endif

  assign lookup_extended  = scan_code_extended;
  assign lookup_scan_code = scan_code_byte;
  assign lookup_num_lock  = num_lock;
  assign lookup_control   = control;
  assign lookup_caps_lock = caps_lock;
  assign lookup_shift     = shift;

  // A key is started only when the longest sequence (7 bytes) is guaranteed to fit.
  assign room = (LW'(FIFO_DEPTH) - level) >= LW'(7);

  logic       num_form, multi;
  logic [7:0] ones_byte, final_byte;
  assign num_form   = key_q[6];
  assign multi      = mod_q > 4'd1;
  assign ones_byte  = num_form ? {4'h3, key_q[3:0]} : 8'h31;
  assign final_byte = num_form ? 8'h7E : {3'b010, key_q[4:0]};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next      = state;
    push            = 1'b0;
    push_byte       = 8'h00;
    lookup_ce       = 1'b0;
    scan_code_ready = 1'b0;
    case (state)
      S_IDLE: begin
        scan_code_ready = room;
        if (scan_code_valid && room && !scan_code_special) begin
          lookup_ce  = 1'b1;
          state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (key_code_q == 8'h00) begin
          state_next = S_IDLE;
        end else if (!key_code_q[7]) begin
          push       = 1'b1;
          push_byte  = {1'b0, key_code_q[6:0]};
          state_next = S_IDLE;
        end else begin
          state_next = S_ESC;
        end
      end
      S_ESC: begin
        push      = 1'b1;
        push_byte = 8'h1B;
        if (vt52_q) state_next = num_form ? S_IDLE : S_FINAL;
        else        state_next = S_INTRO;
      end
      S_INTRO: begin
        push      = 1'b1;
        push_byte = (num_form || (key_q[5] && (!app_q || multi))) ? 8'h5B : 8'h4F;
        if (num_form)   state_next = S_TENS;
        else if (multi) state_next = S_ONES;
        else            state_next = S_FINAL;
      end
      S_TENS: begin
        push = 1'b1;
        // A zero tens digit is skipped by emitting the ones digit in this same cycle.
        if (key_q[5:4] != 2'd0) begin
          push_byte  = {6'b001100, key_q[5:4]};
          state_next = S_ONES;
        end else begin
          push_byte  = ones_byte;
          state_next = multi ? S_SEMI : S_FINAL;
        end
      end
      S_ONES: begin
        push       = 1'b1;
        push_byte  = ones_byte;
        state_next = multi ? S_SEMI : S_FINAL;
      end
      S_SEMI: begin
        push       = 1'b1;
        push_byte  = 8'h3B;
        state_next = S_MOD;
      end
      S_MOD: begin
        push       = 1'b1;
        push_byte  = {4'h3, mod_q};
        state_next = S_FINAL;
      end
      S_FINAL: begin
        push       = 1'b1;
        push_byte  = final_byte;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state  <= S_IDLE;
      key_q  <= 7'h00;
      vt52_q <= 1'b0;
      app_q  <= 1'b0;
      mod_q  <= 4'd1;
    end else begin
      state <= state_next;
      if (state == S_LOOKUP) begin
        key_q  <= key_code_q[6:0];
        vt52_q <= vt52_mode;
        app_q  <= cursor_app_mode;
        mod_q  <= mod_now;
      end
    end
  end

  assign pop = (level != '0) && character_ready;

  // NOTE: the storage array is not reset; emptiness is tracked by level alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign character_valid = (level != '0);
  assign character_byte  = character_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_level      = level;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: directed keys, a sequence-level model feeding a byte scoreboard,
// and literal sequence expectations for each key.
module tb_ps2_key_sequencer;

  logic       clk = 1'b0;
  logic       reset_low = 1'b0;
  logic       scan_code_ready, scan_code_valid = 1'b0;
  logic [7:0] scan_code_byte = 8'h00;
  logic       scan_code_extended = 1'b0, scan_code_special = 1'b0;
  logic       num_lock = 1'b0, control = 1'b0, caps_lock = 1'b0, shift = 1'b0, alt = 1'b0;
  logic       vt52_mode = 1'b0, cursor_app_mode = 1'b0;
  logic       lookup_ce, lookup_extended;
  logic [7:0] lookup_scan_code;
  logic       lookup_num_lock, lookup_control, lookup_caps_lock, lookup_shift;
  logic [7:0] key_code_q = 8'h00;
  logic       character_ready = 1'b1;
  logic       character_valid;
  logic [7:0] character_byte;
  logic [3:0] fifo_level;

  int total = 0;
  int bad = 0;
  int ce_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  ps2_key_sequencer #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_low(reset_low),
    .scan_code_ready(scan_code_ready), .scan_code_valid(scan_code_valid),
    .scan_code_byte(scan_code_byte), .scan_code_extended(scan_code_extended),
    .scan_code_special(scan_code_special),
    .num_lock(num_lock), .control(control), .caps_lock(caps_lock), .shift(shift), .alt(alt),
    .vt52_mode(vt52_mode), .cursor_app_mode(cursor_app_mode),
    .lookup_ce(lookup_ce), .lookup_extended(lookup_extended), .lookup_scan_code(lookup_scan_code),
    .lookup_num_lock(lookup_num_lock), .lookup_control(lookup_control),
    .lookup_caps_lock(lookup_caps_lock), .lookup_shift(lookup_shift),
    .key_code_q(key_code_q), .character_ready(character_ready),
    .character_valid(character_valid), .character_byte(character_byte), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic ext, input logic [7:0] sc);
    case ({ext, sc})
      {1'b0, 8'h1C}: rom = 8'h61;  // 'a'
      {1'b1, 8'h75}: rom = 8'hA1;  // Up: letter form, bracket, letter 1
      {1'b0, 8'h03}: rom = 8'hD5;  // F5: tens 1, ones 5
      {1'b1, 8'h70}: rom = 8'hC2;  // Insert: tens 0, ones 2
      {1'b0, 8'h05}: rom = 8'h90;  // F1: letter form, no bracket, letter 0x10
      default:       rom = 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (lookup_ce) begin
      key_code_q <= rom(lookup_extended, lookup_scan_code);
      ce_count   <= ce_count + 1;
    end
  end

  // Sequence model: what the terminal must receive for one key, from the key-code rules.
  task automatic model(input logic [7:0] kc);
    int   m;
    logic num;
`ifdef PS2_KEY_SEQUENCER_MODIFIERS_EN
    m = 1 + int'(shift) + 2 * int'(alt) + 4 * int'(control);
`else
    m = 1;
`endif
    if (kc == 8'h00) return;
    if (!kc[7]) begin
      exp_q.push_back({1'b0, kc[6:0]});
      return;
    end
    num = kc[6];
    exp_q.push_back(8'h1B);
    if (vt52_mode) begin
      if (!num) exp_q.push_back(8'h40 | {3'b000, kc[4:0]});
      return;
    end
    if (num) begin
      exp_q.push_back("[");
      if (kc[5:4] != 2'd0) exp_q.push_back(8'h30 + {6'd0, kc[5:4]});
      exp_q.push_back(8'h30 + {4'd0, kc[3:0]});
      if (m > 1) begin
        exp_q.push_back(";");
        exp_q.push_back(8'h30 + 8'(m));
      end
      exp_q.push_back("~");
    end else begin
      exp_q.push_back((kc[5] && (!cursor_app_mode || m > 1)) ? "[" : "O");
      if (m > 1) begin
        exp_q.push_back("1");
        exp_q.push_back(";");
        exp_q.push_back(8'h30 + 8'(m));
      end
      exp_q.push_back(8'h40 | {3'b000, kc[4:0]});
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard: every byte the consumer takes must be the next model byte.
  always @(negedge clk) begin
    if (character_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h want none", character_byte);
      end else begin
        check("stream_byte", character_byte, exp_q[0]);
      end
      if (character_ready) begin
        got_q.push_back(character_byte);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end else begin
      check("empty_byte", character_byte, 8'h00);
    end
  end

  task automatic send(input logic [7:0] sc, input logic ext, input logic special);
    bit ok = 0;
    @(posedge clk); #1;
    scan_code_valid    = 1'b1;
    scan_code_byte     = sc;
    scan_code_extended = ext;
    scan_code_special  = special;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (scan_code_ready) ok = 1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready=0 want ready=1");
    end else if (!special) begin
      model(rom(ext, sc));
    end
    @(posedge clk); #1;
    scan_code_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !character_valid) done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic check_seq(input string name, input logic [55:0] want, input int n);
    logic [55:0] g = '0;
    int          sz = got_q.size();
    foreach (got_q[i]) g = {g[47:0], got_q[i]};
    total++;
    if (sz != n || g != want) begin
      bad++;
      $display("FAIL %s: got %0d bytes %h want %0d bytes %h", name, sz, g, n, want);
    end
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ce_before;
    repeat (3) @(negedge clk);
    check("rst_valid", character_valid, 1'b0);
    check("rst_byte", character_byte, 8'h00);
    check("rst_level", fifo_level, 4'd0);
    check("rst_ce", lookup_ce, 1'b0);
    @(posedge clk); #1 reset_low = 1'b1;
    @(negedge clk);
    check("ready_after_rst", scan_code_ready, 1'b1);

    num_lock = 1'b1;
    #1 check("pass_through_a", {lookup_num_lock, lookup_control, lookup_caps_lock, lookup_shift}, 4'b1000);
    num_lock = 1'b0; caps_lock = 1'b1; shift = 1'b1;
    #1 check("pass_through_b", {lookup_num_lock, lookup_control, lookup_caps_lock, lookup_shift}, 4'b0011);
    caps_lock = 1'b0; shift = 1'b0;

    // Plain character and its latency: accept cycle 0, valid appears in cycle 2.
    send(8'h1C, 1'b0, 1'b0);
    @(negedge clk); check("lat_cycle1", character_valid, 1'b0);
    @(negedge clk); check("lat_cycle2", character_valid, 1'b1);
    drain(); check_seq("plain_a", 56'h61, 1);

    send(8'h75, 1'b1, 1'b0); drain(); check_seq("up_ansi", 56'h1B5B41, 3);
    cursor_app_mode = 1'b1;
    send(8'h75, 1'b1, 1'b0); drain(); check_seq("up_app", 56'h1B4F41, 3);
    cursor_app_mode = 1'b0; vt52_mode = 1'b1;
    send(8'h75, 1'b1, 1'b0); drain(); check_seq("up_vt52", 56'h1B41, 2);
    send(8'h03, 1'b0, 1'b0); drain(); check_seq("f5_vt52", 56'h1B, 1);
    vt52_mode = 1'b0;

    send(8'h03, 1'b0, 1'b0); drain(); check_seq("f5", 56'h1B5B31357E, 5);
    send(8'h70, 1'b1, 1'b0); drain(); check_seq("insert", 56'h1B5B327E, 4);
    send(8'h05, 1'b0, 1'b0); drain(); check_seq("f1", 56'h1B4F50, 3);
    send(8'h99, 1'b0, 1'b0); drain(); check_seq("rom_zero", 56'h0, 0);

    ce_before = ce_count;
    send(8'hF0, 1'b0, 1'b1); drain(); check_seq("special", 56'h0, 0);
    check("special_no_ce", ce_count, ce_before);

    control = 1'b1;
    send(8'h75, 1'b1, 1'b0); drain();
`ifdef PS2_KEY_SEQUENCER_MODIFIERS_EN
    check_seq("ctrl_up", 56'h1B5B313B3541, 6);
`else
    check_seq("ctrl_up", 56'h1B5B41, 3);
`endif
    control = 1'b0; shift = 1'b1;
    send(8'h03, 1'b0, 1'b0); drain();
`ifdef PS2_KEY_SEQUENCER_MODIFIERS_EN
    check_seq("shift_f5", 56'h1B5B31353B327E, 7);
`else
    check_seq("shift_f5", 56'h1B5B31357E, 5);
`endif
    shift = 1'b0; alt = 1'b1;
    send(8'h75, 1'b1, 1'b0); drain();
`ifdef PS2_KEY_SEQUENCER_MODIFIERS_EN
    check_seq("alt_up", 56'h1B5B313B3341, 6);
`else
    check_seq("alt_up", 56'h1B5B41, 3);
`endif
    alt = 1'b0;

    // Backpressure: F5 parks 5 bytes, blocking new keys until the level falls to 1.
    character_ready = 1'b0;
    send(8'h03, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    check("stall_level", fifo_level, 4'd5);
    check("stall_ready", scan_code_ready, 1'b0);
    @(posedge clk); #1 character_ready = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (scan_code_ready) seen = 1;
      end
      check("ready_returns", seen, 1'b1);
      check("ready_level", fifo_level, 4'd1);
    end
    drain(); check_seq("stall_f5", 56'h1B5B31357E, 5);

    // Asynchronous reset in the middle of a control+F5 sequence.
    character_ready = 1'b0; control = 1'b1;
    send(8'h03, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    #2 reset_low = 1'b0;
    #1;
    check("midrst_valid", character_valid, 1'b0);
    check("midrst_level", fifo_level, 4'd0);
    check("midrst_byte", character_byte, 8'h00);
    exp_q.delete();
    got_q.delete();
    repeat (2) @(negedge clk);
    #2 reset_low = 1'b1;
    control = 1'b0; character_ready = 1'b1;
    @(negedge clk);
    check("midrst_ready", scan_code_ready, 1'b1);
    send(8'h1C, 1'b0, 1'b0); drain(); check_seq("after_rst", 56'h61, 1);
    send(8'h75, 1'b1, 1'b0); drain(); check_seq("after_rst_up", 56'h1B5B41, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
